wbs_spi_master: RTL

WBS_SPI_MASTER -- requirements
Module: wbs_spi_master

---
 rtl/wbs_spi_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/wbs_spi_master.sv
// Wishbone B4 pipelined slave that drives a single-byte SPI master.
// It runs in mode 0, sends MSB first and moves 8 bits per transfer.
// Software drives the slave select directly through the CTRL register.
module wbs_spi_master #(
   parameter int WB_CLK_HZ  = 48_000_000,
   parameter int SPI_CLK_HZ = 1_000_000
) (
   input  logic        wbs_clk_i,
   input  logic        wbs_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_adr_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_stall_o,
   output logic        wbs_ack_o,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_ss
);

   // Number of wishbone cycles in each SCK phase. The parameters must make this at least 1.
   localparam int HALF   = WB_CLK_HZ / (2 * SPI_CLK_HZ);
   localparam int TICK_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HALF - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   logic              ack_q,      ack_d;
   logic [31:0]       dat_o_q,    dat_o_d;
   logic [1:0]        state_q,    state_d;
   logic [TICK_W-1:0] tick_q,     tick_d;
   logic [2:0]        bit_cnt_q,  bit_cnt_d;
   logic [7:0]        tx_q,       tx_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic [7:0]        rx_byte_q,  rx_byte_d;
   logic              rx_valid_q, rx_valid_d;
   logic              overrun_q,  overrun_d;
   logic              ss_en_q,    ss_en_d;
   logic              sck_q,      sck_d;
   logic              mosi_q,     mosi_d;

   logic req, rd, data_wr, ctrl_wr, data_rd, busy;

   // These inputs are part of the bus interface but have no function in this block.
   logic unused_bits;
   assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

   // Decode the bus request, update the registers and step the SCK phase FSM.
   always_comb begin
      // NOTE: every signal gets a default value first, so no path through this block infers a latch.
      req     = wbs_cyc_i & wbs_stb_i;
      rd      = req & ~wbs_we_i;
      data_wr = req & wbs_we_i & (wbs_adr_i == 4'd0) & wbs_sel_i[0];
      ctrl_wr = req & wbs_we_i & (wbs_adr_i == 4'd1) & wbs_sel_i[0];
      data_rd = rd & (wbs_adr_i == 4'd0);
      busy    = (state_q != ST_IDLE);

      ack_d      = req;
      dat_o_d    = 32'd0;
      state_d    = state_q;
      tick_d     = tick_q;
      bit_cnt_d  = bit_cnt_q;
      tx_d       = tx_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      ss_en_d    = ss_en_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;

      if (rd) begin
         case (wbs_adr_i)
            4'd0:    dat_o_d = {24'd0, rx_byte_q};
            4'd1:    dat_o_d = {28'd0, overrun_q, rx_valid_q, busy, ss_en_q};
            default: dat_o_d = 32'd0;
         endcase
      end

      if (ctrl_wr) begin
         ss_en_d = wbs_dat_i[0];
         if (wbs_dat_i[3]) overrun_d = 1'b0;
      end

      // A completion later in this block overrides this clear.
      // The read still returns the byte that was held before the update.
      if (data_rd) rx_valid_d = 1'b0;

      // A write in the completion cycle still counts as busy.
      if (data_wr && busy) overrun_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (data_wr) begin
               state_d   = ST_LOW;
               tick_d    = '0;
               bit_cnt_d = 3'd0;
               tx_d      = wbs_dat_i[7:0];
               mosi_d    = wbs_dat_i[7];
            end
         end
         ST_LOW: begin
            if (tick_q == TICK_LAST) begin
               state_d    = ST_HIGH;
               tick_d     = '0;
               sck_d      = 1'b1;
               rx_shift_d = {rx_shift_q[6:0], spi_miso};
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         ST_HIGH: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               sck_d  = 1'b0;
               if (bit_cnt_q == 3'd7) begin
                  state_d    = ST_IDLE;
                  mosi_d     = 1'b0;
                  rx_byte_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  state_d   = ST_LOW;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = {tx_q[6:0], 1'b0};
                  mosi_d    = tx_q[6];
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // Register all state. Reset aborts any transfer and drops a request that arrives during reset.
   always_ff @(posedge wbs_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (wbs_rst_i) begin
         ack_q      <= 1'b0;
         dat_o_q    <= 32'd0;
         state_q    <= ST_IDLE;
         tick_q     <= '0;
         bit_cnt_q  <= 3'd0;
         tx_q       <= 8'd0;
         rx_shift_q <= 8'd0;
         rx_byte_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         ss_en_q    <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         dat_o_q    <= dat_o_d;
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         ss_en_q    <= ss_en_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_o_q;
   assign wbs_stall_o = 1'b0;
   assign spi_sck     = sck_q;
   assign spi_mosi    = mosi_q;
   assign spi_ss      = ~ss_en_q;

endmodule
